// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg : shared widths and types for the pipelined MAC unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mac_pkg;

   localparam int IN_W  = 8;
   localparam int ACC_W = 16;

   typedef logic [IN_W-1:0]   operand_t;
   typedef logic [2*IN_W-1:0] product_t;
   typedef logic [ACC_W-1:0]  acc_t;

endpackage : mac_pkg

`default_nettype wire

// File: rtl/mac_unit_pipelined_pipe_reg.sv
// ============================================================================
// pipe_reg : enable-gated register with asynchronous active-low clear
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else if (en) begin
         data_q <= d;
      end
   end

   assign q = data_q;

endmodule : pipe_reg

`default_nettype wire

// File: rtl/mac_unit_pipelined.sv
// ============================================================================
// mac_unit_pipelined : two-stage pipelined acc_out = a*b + acc_in
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mac_unit_pipelined
   import mac_pkg::*;
#(
   parameter int IN_WIDTH  = IN_W,
   parameter int ACC_WIDTH = ACC_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [IN_WIDTH-1:0]  a,
   input  logic [IN_WIDTH-1:0]  b,
   input  logic [ACC_WIDTH-1:0] acc_in,
   output logic [ACC_WIDTH-1:0] acc_out
);

   localparam int PROD_WIDTH = 2 * IN_WIDTH;

   logic [PROD_WIDTH-1:0] prod_d;
   logic [PROD_WIDTH-1:0] prod_q;
   logic [ACC_WIDTH-1:0]  acc_q;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [ACC_WIDTH-1:0]  sum_d;

   assign prod_d = PROD_WIDTH'(a) * PROD_WIDTH'(b);

   pipe_reg #(.WIDTH(PROD_WIDTH)) u_prod_reg (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (prod_d),
      .q   (prod_q)
   );

   pipe_reg #(.WIDTH(ACC_WIDTH)) u_acc_reg (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (acc_in),
      .q   (acc_q)
   );

   // Size cast zero-extends or truncates; the add then wraps modulo 2^ACC_WIDTH.
   assign prod_ext = ACC_WIDTH'(prod_q);
   assign sum_d    = prod_ext + acc_q;

   pipe_reg #(.WIDTH(ACC_WIDTH)) u_out_reg (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (sum_d),
      .q   (acc_out)
   );

endmodule : mac_unit_pipelined

`default_nettype wire

// File: tb/tb_mac_unit_pipelined.sv
// ============================================================================
// tb_mac_unit_pipelined : directed vector bench for mac_unit_pipelined
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mac_unit_pipelined;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [7:0]  a   = '0;
   logic [7:0]  b   = '0;
   logic [15:0] acc_in = '0;
   logic [15:0] acc_out;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] acc_in;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];

   mac_unit_pipelined #(.IN_WIDTH(8), .ACC_WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .a       (a),
      .b       (b),
      .acc_in  (acc_in),
      .acc_out (acc_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] exp);
      total++;
      if (acc_out === exp) passed++;
      else $display("FAIL %s: acc_out=%0d required=%0d", name, acc_out, exp);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vc);
      a = va; b = vb; acc_in = vc;
   endtask

   initial begin
      vecs[0] = '{8'd3,   8'd4,   16'd10,    16'd22};
      vecs[1] = '{8'd5,   8'd6,   16'd0,     16'd30};
      vecs[2] = '{8'd255, 8'd255, 16'd65535, 16'd65024};
      vecs[3] = '{8'd0,   8'd0,   16'd65535, 16'd65535};
      vecs[4] = '{8'd1,   8'd1,   16'd0,     16'd1};
      vecs[5] = '{8'd0,   8'd200, 16'd7,     16'd7};
      vecs[6] = '{8'd16,  8'd16,  16'd65280, 16'd0};
      vecs[7] = '{8'd200, 8'd100, 16'd1234,  16'd21234};

      // Reset held from time zero
      #3;
      check("reset_initial", 16'd0);
      edge1();
      check("reset_held", 16'd0);
      rst = 1'b1;
      en  = 1'b1;

      // Each vector held for two edges, plus a hold check on the first one
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].acc_in);
         edge1();
         edge1();
         check($sformatf("vec%0d", i), vecs[i].exp);
         if (i == 0) begin
            edge1();
            check("vec0_hold", vecs[i].exp);
         end
      end

      // Back-to-back streaming: result i appears two edges after issue i
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drive(vecs[i].a, vecs[i].b, vecs[i].acc_in);
         edge1();
         if (i >= 1 && i - 1 < 8) check($sformatf("stream%0d", i - 1), vecs[i - 1].exp);
      end

      // Asynchronous reset between edges
      drive(8'd10, 8'd20, 16'd100);
      edge1();
      edge1();
      check("pre_reset", 16'd300);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_immediate", 16'd0);
      edge1();
      check("reset_beats_en", 16'd0);
      #2;
      rst = 1'b1;
      edge1();
      check("post_release_1", 16'd0);
      edge1();
      check("post_release_2", 16'd300);

      // Reset while an operation is in flight
      drive(8'd3, 8'd4, 16'd10);
      edge1();
      edge1();
      edge1();
      drive(8'd3, 8'd4, 16'd10);
      rst = 1'b0; #2; rst = 1'b1;
      edge1();
      drive(8'd3, 8'd4, 16'd10);
      edge1();
      #2;
      rst = 1'b0;
      #1;
      check("midflight_reset", 16'd0);
      #1;
      rst = 1'b1;
      en  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge1();
         check($sformatf("midflight_flushed%0d", i), 16'd0);
      end

      // Enable stall: operands seen while disabled never reach the output
      drive(8'd7, 8'd8, 16'd50);
      for (int i = 0; i < 3; i++) begin
         edge1();
         check($sformatf("stall_idle%0d", i), 16'd0);
      end
      en = 1'b1;
      edge1();
      check("stall_resume_1", 16'd0);
      edge1();
      check("stall_resume_2", 16'd106);

      // Stall with a result in flight
      drive(8'd2, 8'd3, 16'd1);
      edge1();
      check("inflight_issue", 16'd106);
      en = 1'b0;
      drive(8'd9, 8'd9, 16'd9);
      for (int i = 0; i < 3; i++) begin
         edge1();
         check($sformatf("inflight_frozen%0d", i), 16'd106);
      end
      drive(8'd2, 8'd3, 16'd1);
      en = 1'b1;
      edge1();
      check("inflight_resume", 16'd7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: acc_out=%0d required=completion", acc_out);
      $fatal(1, "timeout");
   end

endmodule : tb_mac_unit_pipelined

`default_nettype wire
